// File: rtl/stream_accum_pkg.sv
// Shared types and helpers for the stream_accum reduction block.
package stream_accum_pkg;

  // Control states: ACC collects input words, RESP presents the sum.
  typedef enum logic {
    ACC  = 1'b0,
    RESP = 1'b1
  } state_t;

  // Observation bundle for checkers: current control state and the
  // "next input completes the group" flag from the datapath.
  typedef struct packed {
    state_t state;
    logic   last;
  } stream_accum_dbg_t;

  // Counter width for a group of n words; one extra bit so that n itself
  // is representable and n == 1 still yields a 1-bit counter.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/stream_accum_dpath.sv
// Datapath for stream_accum: accumulator, adder, word counter and the
// last-word compare that tells the control FSM when a group completes.
module stream_accum_dpath
  import stream_accum_pkg::*;
#(
  parameter int p_width = 32,
  parameter int p_nmsgs = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_en,
  input  logic               clr,
  input  logic [p_width-1:0] req_msg,
  output logic [p_width-1:0] acc,
  output logic               last
);

  localparam int CW = cnt_width(p_nmsgs);
  localparam logic [CW-1:0] LAST_CNT = CW'(p_nmsgs - 1);

  logic [CW-1:0] cnt;

  // Accumulate accepted words; clear on the sum handoff. Adds wrap modulo 2^p_width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_en) begin
      acc <= acc + req_msg;
      cnt <= cnt + CW'(1);
    end
  end

  // The word being accepted at this count closes the group.
  always_comb begin
    last = (cnt == LAST_CNT);
  end

endmodule

// File: rtl/stream_accum.sv
// stream_accum: collects p_nmsgs val/rdy input words and emits their sum
// as one val/rdy output word.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_rdy and resp_val depend only on the FSM state, never
// combinationally on req_val or resp_rdy; resp_msg is held stable while
// resp_val=1 until the consumer takes it.
module stream_accum
  import stream_accum_pkg::*;
#(
  parameter int p_width = 32,
  parameter int p_nmsgs = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_width-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_width-1:0] resp_msg,
  output stream_accum_dbg_t  dbg
);

  state_t state;
  state_t state_nx;
  logic   req_fire;
  logic   resp_fire;
  logic   last;

  stream_accum_dpath #(
    .p_width (p_width),
    .p_nmsgs (p_nmsgs)
  ) u_dpath (
    .clk     (clk),
    .reset   (reset),
    .acc_en  (req_fire),
    .clr     (resp_fire),
    .req_msg (req_msg),
    .acc     (resp_msg),
    .last    (last)
  );

  // State register; reset drops any partial group immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nx  = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    req_fire  = 1'b0;
    resp_fire = 1'b0;
    case (state)
      ACC: begin
        req_rdy  = 1'b1;
        req_fire = req_val;
        if (req_val && last) state_nx = RESP;
      end
      RESP: begin
        resp_val  = 1'b1;
        resp_fire = resp_rdy;
        if (resp_rdy) state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  // Debug view of the control state.
  always_comb begin
    dbg.state = state;
    dbg.last  = last;
  end

endmodule

// File: tb/tb_stream_accum.sv
// Self-checking bench for stream_accum (p_width=32, p_nmsgs=4).
module tb_stream_accum;
  import stream_accum_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_val = 1'b0;
  logic              req_rdy;
  logic [W-1:0]      req_msg = '0;
  logic              resp_val;
  logic              resp_rdy = 1'b0;
  logic [W-1:0]      resp_msg;
  stream_accum_dbg_t dbg;

  stream_accum #(.p_width(W), .p_nmsgs(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg),
    .dbg      (dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard / reference model state
  logic [W-1:0] src_q[$];   // words waiting to be offered
  logic [W-1:0] words[$];   // words accepted in the current group
  logic [W-1:0] exp_q[$];   // completed sums awaiting handoff
  logic [W-1:0] got_q[$];   // sums taken by the sink
  bit src_bubbly = 0;
  bit snk_stall  = 0;
  bit snk_en     = 1;
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of driver + sink + model; starts and ends 1 time unit after a rising edge.
  task automatic cycle();
    logic rf, pf;
    logic [W-1:0] s;
    req_val  = (src_q.size() != 0) && (!src_bubbly || ($urandom_range(0, 1) == 1));
    req_msg  = (src_q.size() != 0) ? src_q[0] : W'($urandom);
    resp_rdy = snk_stall ? ($urandom_range(0, 1) == 1) : snk_en;
    #1;
    chk("req_rdy", W'(req_rdy), W'(exp_q.size() == 0));
    chk("resp_val", W'(resp_val), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("resp_msg", resp_msg, exp_q[0]);
    rf = req_val && req_rdy;
    pf = resp_val && resp_rdy;
    if (rf) begin
      words.push_back(src_q.pop_front());
      if (words.size() == N) begin
        s = '0;
        foreach (words[i]) s = s + words[i];
        exp_q.push_back(s);
        words.delete();
      end
    end
    if (pf) begin
      got_q.push_back(resp_msg);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("drain_timeout", W'(src_q.size() + exp_q.size()), '0);
  endtask

  task automatic push4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    src_q.push_back(a);
    src_q.push_back(b);
    src_q.push_back(c);
    src_q.push_back(d);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req_rdy", W'(req_rdy), W'(1));
    chk("rst_resp_val", W'(resp_val), W'(0));
    chk("rst_resp_msg", resp_msg, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed groups back-to-back, sink always ready
    got_q.delete();
    push4(5, 10, 5, 10);
    push4(2, 10, 3, 11);
    push4(18, 14, 8, 4);
    push4(93, 13, 3, 1);
    drain(100);
    chk("dir_count", W'(got_q.size()), W'(4));
    if (got_q.size() == 4) begin
      chk("dir_sum0", got_q[0], 30);
      chk("dir_sum1", got_q[1], 26);
      chk("dir_sum2", got_q[2], 44);
      chk("dir_sum3", got_q[3], 110);
    end

    // Wrap-around
    got_q.delete();
    push4(32'hFFFF_FFFF, 1, 2, 0);
    drain(50);
    chk("wrap_sum", (got_q.size() != 0) ? got_q[0] : 'x, 32'h0000_0002);

    // Backpressure: sink holds off for 5 cycles once the sum is valid
    got_q.delete();
    snk_en = 0;
    push4(5, 10, 5, 10);
    for (int i = 0; i < 20 && exp_q.size() == 0; i++) cycle();
    chk("bp_sum_ready", W'(exp_q.size()), W'(1));
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_msg", resp_msg, 30);
      chk("bp_resp_val", W'(resp_val), W'(1));
      chk("bp_req_rdy", W'(req_rdy), W'(0));
      cycle();
    end
    snk_en = 1;
    drain(20);
    chk("bp_sum", (got_q.size() != 0) ? got_q[0] : 'x, 30);

    // Bubbly source: sums unchanged, nothing lost
    got_q.delete();
    src_bubbly = 1;
    push4(5, 10, 5, 10);
    push4(2, 10, 3, 11);
    drain(200);
    src_bubbly = 0;
    chk("bub_count", W'(got_q.size()), W'(2));
    if (got_q.size() == 2) begin
      chk("bub_sum0", got_q[0], 30);
      chk("bub_sum1", got_q[1], 26);
    end

    // Reset mid-group after two words
    got_q.delete();
    src_q.push_back(5);
    src_q.push_back(10);
    cycle();
    cycle();
    chk("mid_words_taken", W'(words.size()), W'(2));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_val", W'(resp_val), W'(0));
    chk("mid_rst_req_rdy", W'(req_rdy), W'(1));
    chk("mid_rst_resp_msg", resp_msg, '0);
    words.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push4(2, 10, 3, 11);
    drain(50);
    chk("after_rst_sum", (got_q.size() != 0) ? got_q[0] : 'x, 26);

    // Reset while a sum is waiting
    got_q.delete();
    snk_en = 0;
    push4(1, 2, 3, 4);
    for (int i = 0; i < 20 && exp_q.size() == 0; i++) cycle();
    cycle();
    chk("resp_rst_pre_val", W'(resp_val), W'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("resp_rst_resp_val", W'(resp_val), W'(0));
    chk("resp_rst_req_rdy", W'(req_rdy), W'(1));
    chk("resp_rst_resp_msg", resp_msg, '0);
    exp_q.delete();
    words.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    snk_en = 1;

    // 100 random groups of 8-bit words with source and sink stalls
    got_q.delete();
    src_bubbly = 1;
    snk_stall  = 1;
    for (int g = 0; g < 100; g++) begin
      push4(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end
    drain(20000);
    chk("rand_count", W'(got_q.size()), W'(100));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
